// File: rtl/wb_hyper_arb.sv
// Two-master round-robin Wishbone arbiter in front of the HyperRAM data port.
// Each grant has a bounded burst length and an ack watchdog.
module wb_hyper_arb #(
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  localparam int unsigned BW = 8;
  localparam int unsigned TW = 16;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  localparam logic [BW:0]   BEAT_LIM  = (BW+1)'(BURST_MAX);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
  localparam logic [2:0]    CTI_INCR  = 3'b010;
  localparam logic [2:0]    CTI_EOB   = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [TW-1:0] wd_cnt, wd_nxt;
  logic          wd_fired, wd_fired_nxt;

  logic          req0, req1, pick, other_req;
  logic          own_cyc, own_stb, own_we;
  logic [2:0]    own_cti;
  logic [3:0]    own_sel;
  logic [31:0]   own_adr, own_dat;
  logic [BW:0]   beat_inc;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign pick      = (req0 & req1) ? ~last : req1;
  assign other_req = owner ? req0 : req1;
  assign beat_inc  = {1'b0, beat_cnt} + (BW+1)'(1);

  // Owner-side request mux
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;
  assign own_we  = owner ? m1_we_i  : m0_we_i;
  assign own_cti = owner ? m1_cti_i : m0_cti_i;
  assign own_sel = owner ? m1_sel_i : m0_sel_i;
  assign own_adr = owner ? m1_adr_i : m0_adr_i;
  assign own_dat = owner ? m1_dat_i : m0_dat_i;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      beat_cnt <= '0;
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
      wd_cnt   <= wd_nxt;
      wd_fired <= wd_fired_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last;
    beat_nxt     = beat_cnt;
    wd_nxt       = wd_cnt;
    wd_fired_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          owner_nxt = pick;
          last_nxt  = pick;
          beat_nxt  = '0;
          wd_nxt    = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          beat_nxt = (beat_cnt == '1) ? beat_cnt : beat_inc[BW-1:0];
          wd_nxt   = '0;
        end else if (own_stb) begin
          wd_nxt = wd_cnt + TW'(1);
        end
        // Release wins over preemption, preemption over watchdog
        if (!own_cyc) begin
          state_nxt = GAP;
        end else if (s_ack_i && (beat_inc >= BEAT_LIM) && other_req) begin
          state_nxt = GAP;
        end else if (!s_ack_i && (wd_cnt == WD_LAST)) begin
          state_nxt    = GAP;
          wd_fired_nxt = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_o  = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_cti_o  = 3'b000;
    s_adr_o  = own_adr;
    s_dat_o  = own_dat;
    s_sel_o  = own_sel;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      BUSY: begin
        grant_o  = owner ? 2'b10 : 2'b01;
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        s_we_o   = own_we;
        // Tell the slave to close an incrementing burst that is about to be preempted
        s_cti_o  = (own_cti == CTI_INCR && beat_cnt == BEAT_LAST && other_req) ? CTI_EOB : own_cti;
        m0_ack_o = ~owner & s_ack_i;
        m1_ack_o = owner & s_ack_i;
      end
      GAP: begin
        m0_err_o = wd_fired & ~owner;
        m1_err_o = wd_fired & owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_hyper_arb.sv
// Bench for wb_hyper_arb: directed master traffic, a simple acking slave,
// a per-cycle reference model of the arbitration rules and literal checks.
module tb_wb_hyper_arb;

  localparam int BM = 16;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        wb_rst_n_i;
  logic [31:0] m0_dat_i, m0_adr_i, m1_dat_i, m1_adr_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_dat_o, s_adr_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;

  wb_hyper_arb #(.BURST_MAX(BM), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(wb_rst_n_i),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc_n = 0;

  // Master stimulus state
  int          act[2] = '{0, 0};
  int          left[2] = '{0, 0};
  bit          burst[2] = '{0, 0};
  logic [31:0] adr[2] = '{32'h0, 32'h0};
  logic [1:0]  we_v = 2'b10;
  logic        rst_v = 1'b0;
  bit          hang1 = 1'b0;

  // Statistics for literal checks
  int          acks[2], n_ten, repeats, err_n, err_cyc, cti_force_n;
  int          ten_own[64], ten_acks[64], ten_start[2];
  logic [31:0] a17, last_adr[2];
  logic [1:0]  prev_grant = 2'b00;

  // Reference model state
  int md_owner = -1, md_last = 1, md_beats = 0, md_stall = 0, md_err = -1;
  bit md_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc_n, a, e);
    end
  endtask

  function automatic logic [2:0] cti_of(input int n);
    if (!burst[n]) return 3'b000;
    return (left[n] == 1) ? 3'b111 : 3'b010;
  endfunction

  function automatic logic [11:0] ctl_now();
    return {grant_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
  endfunction

  task automatic drive();
    wb_rst_n_i = rst_v;
    m0_cyc_i = (act[0] != 0); m0_stb_i = (act[0] != 0);
    m1_cyc_i = (act[1] != 0); m1_stb_i = (act[1] != 0);
    m0_adr_i = adr[0]; m1_adr_i = adr[1];
    m0_dat_i = adr[0] ^ 32'hC0DE_0000; m1_dat_i = adr[1] ^ 32'hBEEF_0000;
    m0_sel_i = 4'hF; m1_sel_i = 4'h3;
    m0_we_i = we_v[0]; m1_we_i = we_v[1];
    m0_cti_i = cti_of(0); m1_cti_i = cti_of(1);
  endtask

  task automatic slave();
    s_ack_i = s_cyc_o & s_stb_o & ~(hang1 & grant_o[1]);
    s_dat_i = s_adr_o ^ 32'h0F0F_A5A5;
  endtask

  // Compare DUT against the arbitration rules, then advance the model one edge
  task automatic compare_and_model();
    logic [1:0]  cy, st, wv, e_g;
    logic [2:0]  ct[2];
    logic [31:0] ad[2];
    logic [2:0]  e_t;
    logic        e_c, e_s, e_w, e_a0, e_a1, e_e0, e_e1;
    logic        rq0, rq1, oreq;
    int          o;
    cy = {m1_cyc_i, m0_cyc_i}; st = {m1_stb_i, m0_stb_i}; wv = {m1_we_i, m0_we_i};
    ct[0] = m0_cti_i; ct[1] = m1_cti_i; ad[0] = m0_adr_i; ad[1] = m1_adr_i;
    e_g = 2'b00; e_t = 3'b000;
    {e_c, e_s, e_w, e_a0, e_a1, e_e0, e_e1} = 7'b0;
    o = md_owner;
    if (o >= 0) begin
      oreq = cy[1-o] & st[1-o];
      e_g = (o == 1) ? 2'b10 : 2'b01;
      e_c = cy[o]; e_s = st[o]; e_w = wv[o];
      e_t = (ct[o] == 3'b010 && md_beats == BM - 1 && oreq) ? 3'b111 : ct[o];
      if (o == 0) e_a0 = s_ack_i; else e_a1 = s_ack_i;
      chk("s_adr", s_adr_o, ad[o]);
    end else if (md_gap && md_err >= 0) begin
      if (md_err == 0) e_e0 = 1'b1; else e_e1 = 1'b1;
    end
    chk("ctl", 32'(ctl_now()), 32'({e_g, e_c, e_s, e_w, e_t, e_a0, e_a1, e_e0, e_e1}));
    chk("m0_dat", m0_dat_o, s_dat_i);
    chk("m1_dat", m1_dat_o, s_dat_i);

    if (!wb_rst_n_i) begin
      md_owner = -1; md_gap = 1'b0; md_last = 1; md_err = -1;
    end else if (o >= 0) begin
      oreq = cy[1-o] & st[1-o];
      if (!cy[o] || (s_ack_i && md_beats + 1 >= BM && oreq)) begin
        md_owner = -1; md_gap = 1'b1; md_err = -1;
      end else if (!s_ack_i && md_stall == TO - 1) begin
        md_owner = -1; md_gap = 1'b1; md_err = o;
      end else begin
        if (s_ack_i) begin
          md_beats = (md_beats < 255) ? md_beats + 1 : 255;
          md_stall = 0;
        end else if (st[o]) begin
          md_stall++;
        end
      end
    end else if (md_gap) begin
      md_gap = 1'b0; md_err = -1;
    end else begin
      rq0 = cy[0] & st[0]; rq1 = cy[1] & st[1];
      if (rq0 || rq1) begin
        md_owner = (rq0 && rq1) ? 1 - md_last : (rq1 ? 1 : 0);
        md_last = md_owner; md_beats = 0; md_stall = 0;
      end
    end
  endtask

  // Master-side reaction to acks/errors and tenure statistics
  task automatic book();
    logic a, e;
    int o;
    if (grant_o != 2'b00 && prev_grant == 2'b00 && n_ten < 64) begin
      o = grant_o[1] ? 1 : 0;
      if (n_ten > 0 && ten_own[n_ten-1] == o) repeats++;
      ten_own[n_ten] = o; ten_acks[n_ten] = 0; ten_start[o] = cyc_n;
      n_ten++;
    end
    prev_grant = grant_o;
    if (s_cti_o == 3'b111 && m0_cti_i == 3'b010 && grant_o == 2'b01) cti_force_n++;
    for (int n = 0; n < 2; n++) begin
      a = (n == 1) ? m1_ack_o : m0_ack_o;
      e = (n == 1) ? m1_err_o : m0_err_o;
      if (a) begin
        acks[n]++;
        if (n_ten > 0) ten_acks[n_ten-1]++;
        if (n == 0 && acks[0] == 17) a17 = s_adr_o;
        last_adr[n] = s_adr_o;
        adr[n] = adr[n] + 32'd4;
        left[n]--;
        if (left[n] == 0) act[n] = 0;
      end
      if (e) begin
        err_n++; err_cyc = cyc_n; act[n] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive(); #1;
    slave();
    @(negedge clk);
    cyc_n++;
    compare_and_model();
    book();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_done(input int budget);
    int b = budget;
    while ((act[0] != 0 || act[1] != 0) && b > 0) begin
      step(); b--;
    end
    chk("done", 32'(act[0] | act[1]), 32'd0);
  endtask

  task automatic clear_stats();
    acks = '{0, 0}; n_ten = 0; repeats = 0; err_n = 0; err_cyc = 0; cti_force_n = 0;
    a17 = '0; ten_start = '{0, 0};
  endtask

  task automatic start(input int n, input logic [31:0] a, input int beats, input bit b);
    act[n] = 1; adr[n] = a; left[n] = beats; burst[n] = b;
  endtask

  int mx, b3;

  initial begin
    clear_stats();
    drive();
    s_ack_i = 1'b0; s_dat_i = '0;

    // Reset state
    run(3);
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    rst_v = 1'b1;
    run(2);

    // Single master: four single reads
    clear_stats();
    start(0, 32'h100, 4, 1'b0);
    step();
    chk("t1_idle_grant", 32'(grant_o), 32'd0);
    step();
    chk("t1_grant", 32'(grant_o), 32'd1);
    run_until_done(20);
    run(4);
    chk("t1_acks", acks[0], 4);
    chk("t1_last_adr", last_adr[0], 32'h10C);

    // Tie right after reset
    rst_v = 1'b0; step(); rst_v = 1'b1; step();
    clear_stats();
    start(0, 32'h200, 3, 1'b0);
    start(1, 32'h300, 3, 1'b0);
    run(2);
    chk("t2_first_grant", 32'(grant_o), 32'd1);
    run_until_done(50);
    run(4);
    chk("t2_handover", ten_start[1] - ten_start[0], 6);
    chk("t2_acks0", acks[0], 3);
    chk("t2_acks1", acks[1], 3);

    // Preemption of a 40-beat incrementing burst
    clear_stats();
    start(0, 32'h1000, 40, 1'b1);
    b3 = 50;
    while (acks[0] < 3 && b3 > 0) begin step(); b3--; end
    chk("t3_beat3", acks[0], 3);
    start(1, 32'h2000, 4, 1'b0);
    run_until_done(300);
    run(4);
    chk("t3_tenures", n_ten, 3);
    chk("t3_first_len", ten_acks[0], 16);
    chk("t3_second_own", ten_own[1], 1);
    chk("t3_second_len", ten_acks[1], 4);
    chk("t3_third_len", ten_acks[2], 24);
    chk("t3_resume_adr", a17, 32'h1040);
    chk("t3_cti_force", cti_force_n, 1);
    chk("t3_acks0", acks[0], 40);

    // Starvation bound: both stream continuously
    clear_stats();
    start(0, 32'h3000, 50, 1'b1);
    start(1, 32'h4000, 50, 1'b1);
    run_until_done(600);
    run(4);
    mx = 0;
    for (int i = 0; i < n_ten; i++) if (ten_acks[i] > mx) mx = ten_acks[i];
    chk("t4_max_tenure", mx, 16);
    chk("t4_repeats", repeats, 0);
    chk("t4_tenures", n_ten, 8);
    chk("t4_acks", acks[0] + acks[1], 100);

    // Watchdog on a hung m1 transfer with m0 waiting
    clear_stats();
    hang1 = 1'b1;
    start(1, 32'h5000, 1, 1'b0);
    step();
    start(0, 32'h6000, 2, 1'b0);
    run_until_done(100);
    run(4);
    hang1 = 1'b0;
    chk("t5_err_pulses", err_n, 1);
    chk("t5_err_delay", err_cyc - ten_start[1], 8);
    chk("t5_acks1", acks[1], 0);
    chk("t5_next_owner", ten_own[1], 0);
    chk("t5_acks0", acks[0], 2);

    // Reset in the middle of a burst
    clear_stats();
    start(0, 32'h7000, 20, 1'b1);
    b3 = 50;
    while (acks[0] < 4 && b3 > 0) begin step(); b3--; end
    rst_v = 1'b0;
    step();
    chk("t6_beat5", acks[0], 5);
    step();
    chk("t6_rst_ctl", 32'(ctl_now()), 32'd0);
    run(2);
    act[0] = 0;
    rst_v = 1'b1;
    run(3);
    chk("t6_acks", acks[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_hyper_arb.md
# wb_hyper_arb

Two-master Wishbone arbiter in front of the HyperRAM Wishbone slave data port. It shares the single HyperBus memory port between the capture DMA (master 0) and the soft-CPU data bus (master 1). The arbiter uses round-robin grants and a bounded burst length, so neither master can starve the other. It also has a per-grant ack watchdog that recovers from a hung transfer. The cfg port of the HyperRAM slave is not routed through this block.

## Interface
- BURST_MAX, 16: beats (acks) one grant may take before yielding when the other master is waiting; range 2..255.
- TIMEOUT, 255: cycles with forwarded stb and no ack before the watchdog fires; range 8..65535.

- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_n_i  in  1  reset; synchronous, active-low.
- mN_dat_i  in  32  write data from master N (N = 0, 1).
- mN_adr_i  in  32  byte address.
- mN_sel_i  in  4  byte enables.
- mN_cti_i  in  3  cycle type.
- mN_we_i  in  1  write enable.
- mN_cyc_i  in  1  cycle.
- mN_stb_i  in  1  strobe.
- mN_dat_o  out  32  read data, copy of s_dat_i.
- mN_ack_o  out  1  ack to master N.
- mN_err_o  out  1  watchdog error to master N.
- s_dat_o, s_adr_o  out  32 each  to slave.
- s_sel_o  out  4  to slave.
- s_cti_o  out  3  to slave.
- s_we_o, s_cyc_o, s_stb_o  out  1 each  to slave.
- s_dat_i  in  32  read data from slave.
- s_ack_i  in  1  ack from slave.
- grant_o  out  2  one-hot current owner; 2'b00 when no master owns the port.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: owner g is connected to the slave.
  - GAP: one cycle with s_cyc_o=0, so the slave ends any burst and reads a fresh request.
- IDLE: a request is reqN = mN_cyc_i & mN_stb_i.
  - One requester: grant it.
  - Both requesting: grant the master that is not last_g.
  - On grant: set g, set last_g=g, clear beat_cnt and wd_cnt, go to BUSY next cycle.
- BUSY mux (combinational from owner g):
  - s_adr_o, s_dat_o, s_sel_o, s_we_o forwarded from master g.
  - s_cyc_o = mg_cyc_i.
  - s_stb_o = mg_stb_i.
- BUSY ack and data routing:
  - mg_ack_o = s_ack_i.
  - Non-owner ack_o = 0.
  - Both mN_dat_o = s_dat_i at all times.
- s_cti_o = mg_cti_i, with one exception. It is forced to 3'b111 when all of these hold:
  - mg_cti_i = 3'b010;
  - beat_cnt = BURST_MAX-1;
  - the other master is requesting.
- beat_cnt: 8-bit, increments on each s_ack_i in BUSY, saturates at 255.
- BUSY exits to GAP on the first true condition, evaluated at the clock edge:
  - (a) mg_cyc_i = 0: owner released.
  - (b) s_ack_i=1, beat_cnt+1 ≥ BURST_MAX, and the other master is requesting: preemption.
  - (c) wd_cnt = TIMEOUT-1 and s_ack_i=0: watchdog.
- Preempted master: keeps cyc/stb high and simply sees no ack until it is re-granted. This is legal Wishbone stall behaviour. Its next beat resumes with its own current address.
- Watchdog:
  - wd_cnt counts cycles in BUSY with s_stb_o=1 & s_ack_i=0; it clears on any s_ack_i.
  - On firing: mg_err_o=1 for exactly one cycle (the GAP cycle), and mg_ack_o stays 0.
- GAP:
  - All s_* control outputs 0; grant_o = 2'b00.
  - Any s_ack_i arriving during GAP is dropped and not routed.
  - Next state: IDLE.
- last_g reset value = 1, so master 0 wins the first tie.

## Timing
- Reset outputs: state=IDLE, grant_o=0, s_cyc_o=0, s_stb_o=0, s_we_o=0, s_cti_o=0, mN_ack_o=0, mN_err_o=0. Counters clear; last_g=1.
- Reset mid-transfer aborts the transfer immediately. No ack or err is issued for the aborted transfer.
- Grant latency:
  - Request seen in IDLE at edge k: grant_o and s_stb_o are valid from cycle k+1.
  - Back-to-back owner change costs exactly 2 idle cycles (GAP, IDLE), then the new owner is in BUSY.
- Ack path is combinational, s_ack_i → mg_ack_o, with zero added latency.
- The owner dropping cyc in the same cycle as preemption is treated as a release (a). The outcome is the same: GAP.
- Simultaneous first requests in IDLE go to master 0 after reset. After that, tie-breaks alternate.

## Test plan
- Single master: m0 reads 4 single beats at 0x100..0x10C while m1 is idle. Expected: grant_o=01 from cycle 1 and four m0 acks. After m0 drops cyc: exactly 1 GAP cycle, then grant_o=00.
- Tie after reset: m0 and m1 raise cyc/stb in the same cycle. Expected: m0 granted first. m1 is granted on the IDLE cycle after m0's GAP, 2 cycles after m0 releases.
- Preemption, BURST_MAX=16: m0 runs an incrementing burst (cti=010) of 40 beats; m1 requests at beat 3. Expected:
  - s_cti_o=111 on m0's 16th beat;
  - m0 stalls;
  - m1 is served until it releases;
  - m0 then resumes at the address of its 17th beat;
  - total m0 acks = 40.
- Starvation bound: both masters stream continuously. Expected: grants alternate, and no grant exceeds 16 acks.
- Watchdog, TIMEOUT=8: the slave never acks m1. Expected: m1_err_o pulses 1 cycle, 8 cycles after grant. m1_ack_o stays 0 throughout. The arbiter returns to IDLE and grants waiting m0.
- Reset mid-burst: assert wb_rst_n_i=0 on beat 5 of an m0 burst. Expected: the next edge shows all outputs at their reset values and no further acks.
